// File: rtl/pic_pkg.sv
// pic_pkg: shared state encoding and constants for the PIC acknowledge path.
package pic_pkg;
  typedef enum logic [2:0] {IDLE, REQ, PULSE1, GAP, PULSE2, DONE} state_t;
  localparam logic [2:0] SPURIOUS_ID = 3'd7;
  localparam int VEC_W = 8;
endpackage

// File: rtl/inta_sync.sv
// inta_sync: multi-flop synchronizer for INTA_n with one-cycle fall/rise detect.
module inta_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);
  // sr[SYNC_STAGES-1] is the synchronized level, sr[SYNC_STAGES] its previous value
  logic [SYNC_STAGES:0] sr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sr <= '1;
    else sr <= {sr[SYNC_STAGES-1:0], inta_n};
  assign fall = sr[SYNC_STAGES] & ~sr[SYNC_STAGES-1];
  assign rise = ~sr[SYNC_STAGES] & sr[SYNC_STAGES-1];
endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer: 8086-mode INTA handshake controller; INTA_TIMEOUT_EN adds a GAP watchdog.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             INTA_n,
  input  logic             int_req,
  input  logic [2:0]       priority_id,
  input  logic [4:0]       vector_base,
  input  logic             aeoi,
  input  logic             sngl,
  input  logic             sp,
  input  logic [2:0]       slave_id,
  input  logic [2:0]       cas_in,
  output logic             INT,
  output logic             ack1,
  output logic             ack2,
  output logic             auto_eoi,
  output logic [2:0]       ack_id,
  output logic [2:0]       cas_out,
  output logic             cas_oe,
  output logic [VEC_W-1:0] data_out,
  output logic             data_oe
);
  state_t state, nxt;
  logic fall, rise, spur, hit, tmo;
  logic ack1_d, ack2_d, eoi_d, int_d;
  inta_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk,
    .reset_n,
    .inta_n(INTA_n),
    .fall,
    .rise
  );
`ifdef INTA_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (state != GAP) cnt <= '0;
    else if (cnt != '1) cnt <= cnt + 1'b1;
  assign tmo = state == GAP && !fall && cnt >= CNT_W'(TIMEOUT_CYCLES - 1);
`else
  logic [CNT_W-1:0] unused_tmo_cfg;
  assign unused_tmo_cfg = CNT_W'(TIMEOUT_CYCLES);
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (int_req) nxt = REQ;
      REQ:     if (fall) nxt = PULSE1; else if (!int_req) nxt = IDLE;
      PULSE1:  if (rise) nxt = GAP;
      GAP:     if (fall) nxt = PULSE2; else if (tmo) nxt = IDLE;
      PULSE2:  if (rise) nxt = DONE;
      default: nxt = IDLE;
    endcase
    ack1_d = state == REQ && fall && int_req;
    ack2_d = state == GAP && fall;
    eoi_d  = (state == PULSE2 && rise && aeoi && !spur) || tmo;
    int_d  = nxt inside {REQ, PULSE1, GAP, PULSE2};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      INT      <= 1'b0;
      ack1     <= 1'b0;
      ack2     <= 1'b0;
      auto_eoi <= 1'b0;
      ack_id   <= '0;
      spur     <= 1'b0;
      hit      <= 1'b0;
    end else begin
      state    <= nxt;
      INT      <= int_d;
      ack1     <= ack1_d;
      ack2     <= ack2_d;
      auto_eoi <= eoi_d;
      if (state == REQ && fall) begin
        ack_id <= int_req ? priority_id : SPURIOUS_ID;
        spur   <= !int_req;
      end
      if (ack2_d) hit <= cas_in == slave_id;
    end
  // a cascaded master only steers the slaves; data comes from single mode or an addressed slave
  assign cas_oe   = sp && !sngl && state inside {PULSE1, GAP, PULSE2};
  assign cas_out  = cas_oe ? ack_id : '0;
  assign data_oe  = state == PULSE2 && (sngl || (!sp && hit));
  assign data_out = data_oe ? {vector_base, ack_id} : '0;
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: randomized INTA handshake transactions checked against a transaction-level model.
module tb_inta_sequencer;
  logic clk = 0, reset_n = 0, INTA_n = 1, int_req = 0, aeoi = 0, sngl = 1, sp = 1;
  logic [2:0] priority_id = 0, slave_id = 0, cas_in = 0;
  logic [4:0] vector_base = 0;
  logic INT, ack1, ack2, auto_eoi, cas_oe, data_oe;
  logic [2:0] ack_id, cas_out;
  logic [7:0] data_out;
  int vectors = 0, errors = 0;
  int n1, n2, ne, nd, nc, ovl, early;
  logic [7:0] dval;
  logic [2:0] cval, id2;

  inta_sequencer #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .INTA_n(INTA_n), .int_req(int_req),
    .priority_id(priority_id), .vector_base(vector_base), .aeoi(aeoi),
    .sngl(sngl), .sp(sp), .slave_id(slave_id), .cas_in(cas_in),
    .INT(INT), .ack1(ack1), .ack2(ack2), .auto_eoi(auto_eoi), .ack_id(ack_id),
    .cas_out(cas_out), .cas_oe(cas_oe), .data_out(data_out), .data_oe(data_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n1 = 0; n2 = 0; ne = 0; nd = 0; nc = 0; ovl = 0; early = 0;
    dval = 0; cval = 0; id2 = 0;
  endtask

  task automatic step();
    @(negedge clk);
    if (ack1) n1++;
    if (ack2) begin n2++; id2 = ack_id; end
    if (auto_eoi) ne++;
    if (32'(ack1) + 32'(ack2) + 32'(auto_eoi) > 1) ovl++;
    if (data_oe) begin nd++; dval = data_out; if (n2 == 0) early++; end
    if (cas_oe) begin nc++; cval = cas_out; end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  function automatic logic [19:0] outs();
    return {INT, ack1, ack2, auto_eoi, ack_id, cas_out, cas_oe, data_out, data_oe};
  endfunction

  // mode: 0 single, 1 cascaded master, 2 slave
  task automatic run_txn(input int mode, input bit spur, input logic [2:0] pid, input logic [2:0] sid,
                         input logic [2:0] cin, input logic [4:0] vb, input bit ae);
    logic [2:0] eid;
    bit drive, casm, eoi;
    sngl = mode == 0; sp = mode != 2; slave_id = sid; cas_in = cin;
    vector_base = vb; aeoi = ae; priority_id = pid;
    eid   = spur ? 3'd7 : pid;
    drive = mode == 0 || (mode == 2 && cin == sid);
    casm  = mode == 1;
    eoi   = ae && !spur;
    clr();
    int_req = 1;
    steps(2);
    check("int_up", 32'(INT), 1);
    INTA_n = 0;
    if (spur) begin steps(2); int_req = 0; steps(4); end
    else steps(6);
    INTA_n = 1; int_req = 0;
    steps(6);
    INTA_n = 0;
    steps(6);
    INTA_n = 1;
    steps(6);
    check("ack1_cnt", n1, spur ? 0 : 1);
    check("ack2_cnt", n2, 1);
    check("eoi_cnt", ne, eoi ? 1 : 0);
    check("pulse_ovl", ovl, 0);
    check("data_early", early, 0);
    check("ack_id", 32'(id2), 32'(eid));
    check("data_oe_seen", 32'(nd > 0), 32'(drive));
    if (drive) check("data_out", 32'(dval), 32'({vb, eid}));
    check("cas_oe_seen", 32'(nc > 0), 32'(casm));
    if (casm) check("cas_out", 32'(cval), 32'(eid));
    check("int_down", 32'(INT), 0);
  endtask

  initial begin
    #12;
    check("reset_outs", 32'(outs()), 0);
    @(negedge clk);
    reset_n = 1;
    steps(3);
    run_txn(0, 0, 3'd3, 3'd0, 3'd0, 5'b01000, 0);
    run_txn(0, 0, 3'd5, 3'd0, 3'd0, 5'b10101, 1);
    run_txn(0, 0, 3'd5, 3'd0, 3'd0, 5'b10101, 0);
    run_txn(0, 1, 3'd2, 3'd0, 3'd0, 5'b11111, 1);
    run_txn(1, 0, 3'd2, 3'd0, 3'd0, 5'b00110, 0);
    run_txn(2, 0, 3'd6, 3'd4, 3'd4, 5'b01010, 1);
    run_txn(2, 0, 3'd6, 3'd4, 3'd1, 5'b01010, 1);
    for (int i = 0; i < 40; i++) begin
      int m;
      logic [2:0] sid, cin;
      m = $urandom_range(0, 2);
      sid = 3'($urandom);
      cin = ($urandom_range(0, 1) == 1) ? sid : sid ^ 3'($urandom_range(1, 7));
      run_txn(m, $urandom_range(0, 3) == 0, 3'($urandom), sid, cin, 5'($urandom), 1'($urandom));
    end
    sngl = 1; sp = 1; aeoi = 1; priority_id = 3'd1;
    clr();
    int_req = 1;
    steps(2);
    INTA_n = 0;
    steps(6);
    INTA_n = 1; int_req = 0;
    steps(4);
    check("gap_int", 32'(INT), 1);
    clr();
    reset_n = 0;
    #1;
    check("rst_gap_outs", 32'(outs()), 0);
    steps(3);
    reset_n = 1;
    steps(10);
    check("rst_no_pulse", n1 + n2 + ne, 0);
    check("rst_int", 32'(INT), 0);
`ifdef INTA_TIMEOUT_EN
    aeoi = 0;
    int_req = 1;
    steps(2);
    INTA_n = 0;
    steps(6);
    INTA_n = 1; int_req = 0;
    clr();
    steps(30);
    check("tmo_eoi", ne, 1);
    check("tmo_no_ack2", n2, 0);
    check("tmo_int", 32'(INT), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Clocked controller that runs the 8086-mode interrupt-acknowledge handshake for the PIC.
- Raises INT from the resolver's request flag and tracks the two INTA pulses.
- Latches the winning IRQ index and issues ack pulses to the in-service register and cascade logic.
- Drives the vector byte on the second pulse and signals automatic EOI. Sits between priority resolver, ISR, cascade and data-bus driver.

Parameters:
- SYNC_STAGES, 2, flops in the INTA_n synchronizer (minimum 2).
- TIMEOUT_CYCLES, 255, maximum clk cycles allowed between INTA pulses (used only with the optional feature).
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- INTA_n  in  1  CPU acknowledge, asynchronous, active low.
- int_req  in  1  pending unmasked request from the priority resolver.
- priority_id  in  3  winning IRQ index from the resolver.
- vector_base  in  5  ICW2 bits T7..T3.
- aeoi  in  1  ICW4 AEOI mode.
- sngl  in  1  ICW1 single mode.
- sp  in  1  1 = master, 0 = slave.
- slave_id  in  3  ICW3 slave identity.
- cas_in  in  3  cascade lines as seen by a slave.
- INT  out  1  interrupt to CPU.
- ack1  out  1  one-cycle pulse: set ISR bit.
- ack2  out  1  one-cycle pulse: second acknowledge.
- auto_eoi  out  1  one-cycle pulse: clear ISR bit when aeoi = 1.
- ack_id  out  3  latched IRQ index (stable from ack1 until IDLE).
- cas_out  out  3  master cascade drive.
- cas_oe  out  1  cascade output enable.
- data_out  out  8  vector byte.
- data_oe  out  1  data-bus output enable.

Behaviour:
- Reset (asynchronous, reset_n = 0): state = IDLE; all outputs 0; synchronizer flops = 1 (INTA inactive).
- INTA_n passes through SYNC_STAGES flops. fall and rise are one-cycle edge detects on the synchronized signal.
- IDLE: when int_req = 1, go to REQ. INT = 1 is registered, so it is visible the cycle after int_req rises.
- REQ:
  - If int_req drops before fall, return to IDLE and drop INT.
  - On fall, latch ack_id = priority_id, pulse ack1, go to PULSE1.
  - If int_req = 0 on the same cycle as fall, latch ack_id = 7 (spurious IRQ7) and do not pulse ack1.
- PULSE1: on rise, go to GAP. If master (sp = 1) and sngl = 0, set cas_oe = 1 and cas_out = ack_id from the ack1 cycle through the end of PULSE2.
- GAP: on fall, pulse ack2 and go to PULSE2.
- PULSE2:
  - data_oe = 1 and data_out = {vector_base, ack_id} while in PULSE2.
  - Exception: a cascaded master (sngl = 0, sp = 1) never drives data.
  - Exception: a slave drives data only if cas_in == slave_id, sampled at the ack2 cycle.
  - On rise: pulse auto_eoi if aeoi = 1 and the IRQ was not spurious; clear INT; go to DONE.
- DONE: one cycle, all enables 0, then IDLE. INT may re-assert from IDLE on the next request.
- INT stays 1 from REQ through PULSE2.
- fall while in PULSE1 or PULSE2 (glitch or missed rise): ignored.
- Reset during any state: immediate return to IDLE with all enables 0; no ack or EOI pulse is emitted.
- ack1, ack2 and auto_eoi are mutually exclusive and each lasts exactly one cycle.

Optional Feature:
- INTA_TIMEOUT_EN defined:
  - A CNT_W-bit counter clears on entry to GAP and increments each cycle in GAP.
  - If it reaches TIMEOUT_CYCLES, go to IDLE, clear INT and enables, and pulse auto_eoi regardless of aeoi so the ISR bit is released.
  - The counter saturates and does not wrap.
- INTA_TIMEOUT_EN undefined: no counter; GAP waits indefinitely.

Decomposition:
- Shared package pic_pkg holds:
  - state enum: IDLE, REQ, PULSE1, GAP, PULSE2, DONE;
  - SPURIOUS_ID = 3'd7;
  - VEC_W = 8.
- One natural sub-module: inta_sync (SYNC_STAGES synchronizer plus fall/rise detect).

Test Plan:
- Single mode, vector_base = 5'b01000, int_req = 1, priority_id = 3 → INT = 1; two INTA pulses → ack1 then ack2 one cycle each; data_out = 8'h43 with data_oe during the second pulse; INT = 0 afterwards.
- aeoi = 1, priority_id = 5 → auto_eoi pulses once on the second rise; with aeoi = 0, auto_eoi never pulses.
- int_req drops on the same cycle as the first fall, base = 5'b11111 → no ack1; data_out = 8'hFF; no auto_eoi.
- Master cascade (sp = 1, sngl = 0), priority_id = 2 → cas_out = 3'd2 with cas_oe from ack1 through PULSE2; data_oe stays 0.
- Slave (sp = 0), slave_id = 4:
  - cas_in = 4 → vector driven;
  - cas_in = 1 → data_oe stays 0 on both pulses.
- Reset_n pulsed low in GAP → all outputs 0 at once, no pulses. With INTA_TIMEOUT_EN and TIMEOUT_CYCLES = 10, a stalled GAP returns to IDLE after 10 cycles with one auto_eoi pulse.
